// File: rtl/hopfield_pkg.sv
// rtl/hopfield_pkg.sv - shared constants, FSM state type and saturation helper
// Ports: none (package). Imported by the neuron step, the network top and the bench.
package hopfield_pkg;

  localparam int V_RESET    = -65;
  localparam int U_RESET    = -13;
  localparam int V_PEAK     = 30;
  localparam int D_INC      = 8;
  localparam int BIAS_PAT   = 1024;
  localparam int BIAS_LEARN = 2048;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_UPDATE,
    S_LEARN,
    S_FINISH
  } state_t;

  // Clamp a 32-bit signed value into the signed range of a w-bit word.
  function automatic int sat32(input int x, input int w);
    int hi;
    int lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/hopfield_tdm_network_if.sv
// rtl/hopfield_tdm_network_if.sv - control/status bundle of the Hopfield TDM network
// Signals: start/learn/pattern (sweep request, driven by master),
//          busy/done/spikes/weights_flat/sweep_count (status, driven by slave).
interface hopfield_tdm_network_if #(
  parameter int N  = 7,
  parameter int WW = 8
);
  logic              start;
  logic              learn;
  logic [N-1:0]      pattern;
  logic              busy;
  logic              done;
  logic [N-1:0]      spikes;
  logic [N*N*WW-1:0] weights_flat;
  logic [15:0]       sweep_count;

  modport master (
    output start, learn, pattern,
    input  busy, done, spikes, weights_flat, sweep_count
  );

  modport slave (
    input  start, learn, pattern,
    output busy, done, spikes, weights_flat, sweep_count
  );
endinterface

// File: rtl/izhikevich_step.sv
// rtl/izhikevich_step.sv - combinational single-neuron Izhikevich update
// Ports: v_i, u_i, ieff_i   current membrane state and effective input current
//        v_next_o, u_next_o next state (saturated to SW bits)
//        spike_o            high when the neuron fires on this step
module izhikevich_step
  import hopfield_pkg::*;
#(
  parameter int SW = 16
) (
  input  logic signed [SW-1:0] v_i,
  input  logic signed [SW-1:0] u_i,
  input  logic signed [SW-1:0] ieff_i,
  output logic signed [SW-1:0] v_next_o,
  output logic signed [SW-1:0] u_next_o,
  output logic                 spike_o
);

  logic signed [31:0] v32;
  logic signed [31:0] u32;
  logic signed [31:0] i32;
  logic signed [31:0] quad;
  logic signed [31:0] vn;
  logic signed [31:0] un;

  always_comb begin
    v32  = {{(32-SW){v_i[SW-1]}}, v_i};
    u32  = {{(32-SW){u_i[SW-1]}}, u_i};
    i32  = {{(32-SW){ieff_i[SW-1]}}, ieff_i};
    // 0.04*v^2 approximated as 41/1024 * v^2.
    quad = (v32 * v32 * 32'sd41) >>> 10;
    vn   = v32 + quad + 32'sd5 * v32 + 32'sd140 - u32 + i32;
    // Recovery uses the pre-step v and u.
    un   = u32 + ((v32 - 32'sd5 * u32) >>> 8);
    spike_o = (vn >= V_PEAK);
    if (spike_o) begin
      v_next_o = SW'(V_RESET);
      u_next_o = SW'(sat32(un + D_INC, SW));
    end else begin
      v_next_o = SW'(sat32(vn, SW));
      u_next_o = SW'(sat32(un, SW));
    end
  end

endmodule

// File: rtl/hopfield_tdm_network.sv
// rtl/hopfield_tdm_network.sv - time-multiplexed N-neuron Hopfield network with Hebbian learning
// Ports: clk_i   rising-edge clock
//        reset_i synchronous active-high reset
//        bus     slave side of hopfield_tdm_network_if (start/learn/pattern in,
//                busy/done/spikes/weights_flat/sweep_count out)
module hopfield_tdm_network
  import hopfield_pkg::*;
#(
  parameter int N  = 7,
  parameter int WW = 8,
  parameter int SW = 16
) (
  input logic                   clk_i,
  input logic                   reset_i,
  hopfield_tdm_network_if.slave bus
);

  localparam int IW = $clog2(N);
  localparam int AW = WW + IW;
  localparam logic signed [WW-1:0] W_MAX = {1'b0, {(WW-1){1'b1}}};
  localparam logic signed [WW-1:0] W_ONE = WW'(1);

  state_t                state_q;
  logic [IW-1:0]         i_q;
  logic [IW-1:0]         j_q;
  logic signed [AW-1:0]  acc_q;
  logic                  learn_q;
  logic [N-1:0]          pattern_q;
  logic [N-1:0]          next_spk_q;
  logic [N-1:0]          spikes_q;
  logic                  busy_q;
  logic                  done_q;
  logic [15:0]           count_q;
  logic signed [WW-1:0]  w_q [N][N];
  logic signed [SW-1:0]  v_q [N];
  logic signed [SW-1:0]  u_q [N];

  logic signed [WW-1:0]  w_sel_d;
  logic signed [AW-1:0]  w_ext_d;
  logic signed [31:0]    acc32_d;
  int                    bias_d;
  logic signed [SW-1:0]  ieff_d;
  logic signed [SW-1:0]  v_d;
  logic signed [SW-1:0]  u_d;
  logic                  spk_d;
  logic [N-1:0]          spk_vec_d;

  always_comb begin
    w_sel_d = w_q[i_q][j_q];
    w_ext_d = {{IW{w_sel_d[WW-1]}}, w_sel_d};
    acc32_d = {{(32-AW){acc_q[AW-1]}}, acc_q};
    bias_d  = 0;
    if (pattern_q[i_q]) begin
      bias_d = BIAS_PAT;
      if (learn_q) bias_d = bias_d + BIAS_LEARN;
    end
    ieff_d = SW'(sat32((bias_d >>> 6) + acc32_d, SW));
  end

  // On the last UPDATE of a recall sweep the spike vector is published on the
  // same edge, so the current neuron's spike is merged in combinationally.
  always_comb begin
    spk_vec_d = next_spk_q;
    spk_vec_d[i_q] = spk_d;
  end

  izhikevich_step #(.SW(SW)) u_step (
    .v_i      (v_q[i_q]),
    .u_i      (u_q[i_q]),
    .ieff_i   (ieff_d),
    .v_next_o (v_d),
    .u_next_o (u_d),
    .spike_o  (spk_d)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      i_q        <= '0;
      j_q        <= '0;
      acc_q      <= '0;
      learn_q    <= 1'b0;
      pattern_q  <= '0;
      next_spk_q <= '0;
      spikes_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= '0;
      for (int a = 0; a < N; a++) begin
        v_q[a] <= SW'(V_RESET);
        u_q[a] <= SW'(U_RESET);
        for (int b = 0; b < N; b++) w_q[a][b] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            learn_q   <= bus.learn;
            pattern_q <= bus.pattern;
            i_q       <= '0;
            j_q       <= '0;
            acc_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          // Recurrent input comes from the previous sweep's published spikes.
          if (spikes_q[j_q]) acc_q <= acc_q + w_ext_d;
          if (j_q == IW'(N - 1)) state_q <= S_UPDATE;
          else j_q <= j_q + 1'b1;
        end
        S_UPDATE: begin
          v_q[i_q]        <= v_d;
          u_q[i_q]        <= u_d;
          next_spk_q[i_q] <= spk_d;
          if (i_q != IW'(N - 1)) begin
            i_q     <= i_q + 1'b1;
            j_q     <= '0;
            acc_q   <= '0;
            state_q <= S_ACCUM;
          end else if (learn_q) begin
            state_q <= S_LEARN;
          end else begin
            spikes_q <= spk_vec_d;
            done_q   <= 1'b1;
            count_q  <= count_q + 16'd1;
            state_q  <= S_FINISH;
          end
        end
        S_LEARN: begin
          for (int a = 0; a < N; a++) begin
            for (int b = 0; b < N; b++) begin
              if (a != b && next_spk_q[a] && next_spk_q[b] && w_q[a][b] != W_MAX)
                w_q[a][b] <= w_q[a][b] + W_ONE;
            end
          end
          spikes_q <= next_spk_q;
          done_q   <= 1'b1;
          count_q  <= count_q + 16'd1;
          state_q  <= S_FINISH;
        end
        S_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.spikes      = spikes_q;
  assign bus.sweep_count = count_q;

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      assign bus.weights_flat[(gi*N+gj)*WW +: WW] = w_q[gi][gj];
    end
  end

endmodule

// File: tb/tb_hopfield_tdm_network.sv
// tb/tb_hopfield_tdm_network.sv - scoreboard bench for hopfield_tdm_network (N=7/WW=8 and N=4/WW=4)
// Ports: none (top-level bench).
module tb_hopfield_tdm_network;

  localparam int N7  = 7;
  localparam int WW7 = 8;
  localparam int N4  = 4;
  localparam int WW4 = 4;
  localparam int SW  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst7;
  logic rst4;

  hopfield_tdm_network_if #(.N(N7), .WW(WW7)) bus7 ();
  hopfield_tdm_network_if #(.N(N4), .WW(WW4)) bus4 ();

  hopfield_tdm_network #(.N(N7), .WW(WW7), .SW(SW)) dut7 (
    .clk_i   (clk),
    .reset_i (rst7),
    .bus     (bus7)
  );

  hopfield_tdm_network #(.N(N4), .WW(WW4), .SW(SW)) dut4 (
    .clk_i   (clk),
    .reset_i (rst4),
    .bus     (bus4)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act == expv) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
  endtask

  // ---------------- reference model (whole sweep at a time) ----------------
  int         mv [2][16];
  int         mu [2][16];
  int         mw [2][16][16];
  logic [15:0] mspk [2];
  int         mcnt [2];
  int         nn [2] = '{7, 4};
  int         mww [2] = '{8, 4};

  typedef struct packed {
    logic [15:0]   spk;
    logic [15:0]   cnt;
    logic [2047:0] wf;
    logic [255:0]  vf;
    logic [255:0]  uf;
  } exp_t;

  exp_t q7 [$];
  exp_t q4 [$];

  function automatic int msat(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic void model_reset(input int s);
    for (int i = 0; i < 16; i++) begin
      mv[s][i] = -65;
      mu[s][i] = -13;
      for (int j = 0; j < 16; j++) mw[s][i][j] = 0;
    end
    mspk[s] = '0;
    mcnt[s] = 0;
  endfunction

  function automatic void model_sweep(input int s, input logic [15:0] pat, input logic lrn);
    logic [15:0] nsp;
    int n, acc, bias, ieff, v, u, vn, un, wmax;
    n = nn[s];
    wmax = (1 << (mww[s] - 1)) - 1;
    nsp = '0;
    for (int i = 0; i < n; i++) begin
      acc = 0;
      for (int j = 0; j < n; j++) if (mspk[s][j]) acc += mw[s][i][j];
      bias = 0;
      if (pat[i]) bias = lrn ? 3072 : 1024;
      ieff = msat(bias / 64 + acc);
      v = mv[s][i];
      u = mu[s][i];
      vn = v + ((v * v * 41) >>> 10) + 5 * v + 140 - u + ieff;
      un = u + ((v - 5 * u) >>> 8);
      if (vn >= 30) begin
        nsp[i] = 1'b1;
        mv[s][i] = -65;
        mu[s][i] = msat(un + 8);
      end else begin
        mv[s][i] = msat(vn);
        mu[s][i] = msat(un);
      end
    end
    if (lrn) begin
      for (int i = 0; i < n; i++)
        for (int j = 0; j < n; j++)
          if (i != j && nsp[i] && nsp[j] && mw[s][i][j] < wmax) mw[s][i][j]++;
    end
    mspk[s] = nsp;
    mcnt[s] = (mcnt[s] + 1) % 65536;
  endfunction

  function automatic exp_t snap(input int s);
    exp_t e;
    e = '0;
    e.spk = mspk[s];
    e.cnt = 16'(mcnt[s]);
    for (int i = 0; i < 16; i++) begin
      e.vf[i*16 +: 16] = 16'(mv[s][i]);
      e.uf[i*16 +: 16] = 16'(mu[s][i]);
      for (int j = 0; j < 16; j++) e.wf[(i*16+j)*8 +: 8] = 8'(mw[s][i][j]);
    end
    return e;
  endfunction

  // ---------------- field comparison helpers ----------------
  function automatic int w7_bad(input exp_t e);
    int nb = 0;
    for (int i = 0; i < N7; i++)
      for (int j = 0; j < N7; j++)
        if (int'($signed(bus7.weights_flat[(i*N7+j)*WW7 +: WW7])) != int'($signed(e.wf[(i*16+j)*8 +: 8]))) nb++;
    return nb;
  endfunction

  function automatic int w4_bad(input exp_t e);
    int nb = 0;
    for (int i = 0; i < N4; i++)
      for (int j = 0; j < N4; j++)
        if (int'($signed(bus4.weights_flat[(i*N4+j)*WW4 +: WW4])) != int'($signed(e.wf[(i*16+j)*8 +: 8]))) nb++;
    return nb;
  endfunction

  function automatic int vu7_bad(input exp_t e);
    int nb = 0;
    for (int k = 0; k < N7; k++) begin
      if (int'(dut7.v_q[k]) != int'($signed(e.vf[k*16 +: 16]))) nb++;
      if (int'(dut7.u_q[k]) != int'($signed(e.uf[k*16 +: 16]))) nb++;
    end
    return nb;
  endfunction

  function automatic int vu4_bad(input exp_t e);
    int nb = 0;
    for (int k = 0; k < N4; k++) begin
      if (int'(dut4.v_q[k]) != int'($signed(e.vf[k*16 +: 16]))) nb++;
      if (int'(dut4.u_q[k]) != int'($signed(e.uf[k*16 +: 16]))) nb++;
    end
    return nb;
  endfunction

  // ---------------- monitors ----------------
  exp_t e7;
  exp_t e4;

  always @(negedge clk) begin
    if (bus7.done) begin
      if (q7.size() == 0) begin
        check("dut7 unexpected done", 1, 0);
      end else begin
        e7 = q7.pop_front();
        check("dut7 spikes", bus7.spikes, e7.spk[N7-1:0]);
        check("dut7 sweep_count", bus7.sweep_count, e7.cnt);
        check("dut7 wrong weight fields", w7_bad(e7), 0);
        check("dut7 wrong v/u entries", vu7_bad(e7), 0);
      end
    end
  end

  always @(negedge clk) begin
    if (bus4.done) begin
      if (q4.size() == 0) begin
        check("dut4 unexpected done", 1, 0);
      end else begin
        e4 = q4.pop_front();
        check("dut4 spikes", bus4.spikes, e4.spk[N4-1:0]);
        check("dut4 sweep_count", bus4.sweep_count, e4.cnt);
        check("dut4 wrong weight fields", w4_bad(e4), 0);
        check("dut4 wrong v/u entries", vu4_bad(e4), 0);
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic sweep7(input logic [6:0] pat, input logic lrn, input bit extra, input int exp_lat);
    int lat;
    model_sweep(0, {9'b0, pat}, lrn);
    q7.push_back(snap(0));
    @(negedge clk);
    bus7.pattern = pat;
    bus7.learn   = lrn;
    bus7.start   = 1'b1;
    @(negedge clk);
    bus7.start = 1'b0;
    lat = 1;
    check("dut7 busy after start", bus7.busy, 1);
    while (!bus7.done && lat < 200) begin
      @(negedge clk);
      lat++;
      if (extra && lat == 10) begin
        bus7.start   = 1'b1;
        bus7.pattern = ~pat;
        bus7.learn   = 1'b1;
      end
      if (extra && lat == 11) bus7.start = 1'b0;
    end
    check("dut7 done latency", lat, exp_lat);
  endtask

  task automatic sweep4(input logic [3:0] pat, input logic lrn, input int exp_lat);
    int lat;
    model_sweep(1, {12'b0, pat}, lrn);
    q4.push_back(snap(1));
    @(negedge clk);
    bus4.pattern = pat;
    bus4.learn   = lrn;
    bus4.start   = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    lat = 1;
    while (!bus4.done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("dut4 done latency", lat, exp_lat);
  endtask

  task automatic do_reset7();
    @(negedge clk);
    rst7 = 1'b1;
    @(negedge clk);
    rst7 = 1'b0;
    model_reset(0);
  endtask

  task automatic reset_checks7();
    check("dut7 reset spikes", bus7.spikes, 0);
    check("dut7 reset weights nonzero", |bus7.weights_flat, 0);
    check("dut7 reset sweep_count", bus7.sweep_count, 0);
    check("dut7 reset busy", bus7.busy, 0);
    check("dut7 reset done", bus7.done, 0);
    check("dut7 reset v0", int'(dut7.v_q[0]), -65);
    check("dut7 reset u6", int'(dut7.u_q[6]), -13);
  endtask

  function automatic int w7_field(input int i, input int j);
    return int'($signed(bus7.weights_flat[(i*N7+j)*WW7 +: WW7]));
  endfunction

  int vbad;
  int vexp [3] = '{-52, -35, 8};
  logic [6:0] rpat;
  logic       rlrn;

  initial begin
    bus7.start = 1'b0; bus7.learn = 1'b0; bus7.pattern = '0;
    bus4.start = 1'b0; bus4.learn = 1'b0; bus4.pattern = '0;
    rst7 = 1'b1;
    rst4 = 1'b1;
    repeat (3) @(negedge clk);
    rst7 = 1'b0;
    rst4 = 1'b0;
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    reset_checks7();
    check("dut4 reset weights nonzero", |bus4.weights_flat, 0);

    // Quiet recall sweep.
    sweep7(7'b0, 1'b0, 1'b0, 57);
    check("dut7 weights after recall", |bus7.weights_flat, 0);

    // Single driven neuron ramps up and fires on the fourth sweep.
    do_reset7();
    for (int s = 0; s < 4; s++) begin
      sweep7(7'b0000001, 1'b0, 1'b0, 57);
      if (s < 3) check("dut7 neuron0 v ramp", int'(dut7.v_q[0]), vexp[s]);
    end
    check("dut7 spikes after sweep4", bus7.spikes, 7'b0000001);
    check("dut7 neuron0 u after spike", int'(dut7.u_q[0]), -5);
    check("dut7 neuron0 v after spike", int'(dut7.v_q[0]), -65);

    // Long idle run stays sub-threshold.
    do_reset7();
    vbad = 0;
    for (int s = 0; s < 64; s++) begin
      sweep7(7'b0, 1'b0, 1'b0, 57);
      for (int k = 0; k < N7; k++)
        if (int'(dut7.v_q[k]) < -75 || int'(dut7.v_q[k]) > -60) vbad++;
    end
    check("dut7 idle v out of range", vbad, 0);

    // Hebbian learning between two co-firing neurons.
    do_reset7();
    sweep7(7'b0000011, 1'b1, 1'b0, 58);
    sweep7(7'b0000011, 1'b1, 1'b0, 58);
    check("dut7 learn spikes", bus7.spikes, 7'b0000011);
    check("dut7 W01", w7_field(0, 1), 1);
    check("dut7 W10", w7_field(1, 0), 1);
    check("dut7 W00", w7_field(0, 0), 0);

    // Start while busy is ignored.
    sweep7(7'h55, 1'b0, 1'b1, 57);
    repeat (70) @(negedge clk);

    // Reset in the middle of ACCUM aborts the sweep.
    @(negedge clk);
    bus7.pattern = 7'h7f; bus7.learn = 1'b1; bus7.start = 1'b1;
    @(negedge clk);
    bus7.start = 1'b0;
    repeat (9) @(negedge clk);
    check("dut7 busy mid sweep", bus7.busy, 1);
    rst7 = 1'b1;
    @(negedge clk);
    rst7 = 1'b0;
    model_reset(0);
    reset_checks7();
    repeat (70) @(negedge clk);
    sweep7(7'b0000001, 1'b0, 1'b0, 57);

    // Randomised sweeps against the model.
    do_reset7();
    for (int s = 0; s < 40; s++) begin
      rpat = 7'($urandom);
      rlrn = 1'($urandom_range(0, 1));
      sweep7(rpat, rlrn, 1'b0, rlrn ? 58 : 57);
    end

    // Small build: timing, saturation at 2^(WW-1)-1 and flat layout.
    sweep4(4'b1111, 1'b0, 21);
    for (int s = 0; s < 150; s++) sweep4(4'b1111, 1'b1, 22);
    vbad = 0;
    for (int i = 0; i < N4; i++)
      for (int j = 0; j < N4; j++)
        if (int'($signed(bus4.weights_flat[(i*N4+j)*WW4 +: WW4])) != ((i != j) ? 7 : 0)) vbad++;
    check("dut4 saturated layout wrong fields", vbad, 0);

    repeat (3) @(negedge clk);
    check("dut7 scoreboard drained", q7.size(), 0);
    check("dut4 scoreboard drained", q4.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
